// File: rtl/scc_pkg.sv
// Shared constants and types for the execute-stage register interface.
// Holds register-file geometry, CPSR bit layout and write-source encodings.
// Also provides small helpers for CPSR packing and write-data selection.
package scc_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  // CPSR bit positions within the 4-bit flag vector {N, C, Z, V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  // Write-data source encodings for w_select.
  localparam logic W_SEL_ALU = 1'b0;
  localparam logic W_SEL_ID  = 1'b1;

  typedef struct packed {
    logic n;
    logic c;
    logic z;
    logic v;
  } cpsr_t;

  // Build a CPSR struct from a raw flag vector using the named bit positions.
  function automatic cpsr_t cpsr_from_vec(input logic [3:0] vec);
    cpsr_t f;
    f.n = vec[FLAG_N];
    f.c = vec[FLAG_C];
    f.z = vec[FLAG_Z];
    f.v = vec[FLAG_V];
    return f;
  endfunction

  // Flatten a CPSR struct back into the raw flag vector layout.
  function automatic logic [3:0] cpsr_to_vec(input cpsr_t f);
    logic [3:0] vec;
    vec         = 4'b0000;
    vec[FLAG_N] = f.n;
    vec[FLAG_C] = f.c;
    vec[FLAG_Z] = f.z;
    vec[FLAG_V] = f.v;
    return vec;
  endfunction

  // Pick the write-back data source: ALU result or immediate/move result.
  function automatic logic [DATA_W-1:0] wb_src_mux(
    input logic              sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] id
  );
    logic [DATA_W-1:0] res;
    case (sel)
      W_SEL_ALU: res = alu;
      W_SEL_ID:  res = id;
      default:   res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Bus between the EX stage and the write-back / operand-read register block.
// master = EX side (drives write requests, read addresses, flag updates).
// slave  = register block (returns operand values, flags and pending status).
interface reg_file_wb_if;
  import scc_pkg::*;

  // Write request from EX
  logic              w_enable;
  logic              w_select;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_id;

  // CPSR update
  logic              flags_we;
  logic [3:0]        flags_in;

  // Operand read ports
  logic [ADDR_W-1:0] r_addr_0;
  logic [ADDR_W-1:0] r_addr_1;
  logic [DATA_W-1:0] r_val_0;
  logic [DATA_W-1:0] r_val_1;

  // Status
  logic [3:0]        flags;
  logic              wb_pending;

  modport master (
    output w_enable, w_select, w_addr, w_alu, w_id,
    output flags_we, flags_in,
    output r_addr_0, r_addr_1,
    input  r_val_0, r_val_1, flags, wb_pending
  );

  modport slave (
    input  w_enable, w_select, w_addr, w_alu, w_id,
    input  flags_we, flags_in,
    input  r_addr_0, r_addr_1,
    output r_val_0, r_val_1, flags, wb_pending
  );

endinterface

// File: rtl/reg_read_port.sv
// One operand read port: address compare against the staged write plus bypass mux.
// Purely combinational; no read latency.
// The staged write wins over the array so a value is visible the cycle after its request.
module reg_read_port
  import scc_pkg::*;
(
  input  logic [ADDR_W-1:0] r_addr_i,
  input  logic [DATA_W-1:0] arr_val_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] r_val_o
);

  logic hit;

  // Forward the staged write when it targets the address being read.
  always_comb begin
    hit     = wb_valid_i && (wb_addr_i == r_addr_i);
    r_val_o = hit ? wb_data_i : arr_val_i;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Write-back stage register, 8x32 register file with two bypassed read ports, and CPSR.
// Writes are staged one cycle then committed; reads are combinational with bypass.
// No backpressure: every request is accepted, commit of the old entry overlaps the new load.
module reg_file_wb
  import scc_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  reg_file_wb_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;

  cpsr_t             cpsr_q,     cpsr_d;

  logic [DATA_W-1:0] arr_val_0, arr_val_1;

  // Next-state for the stage register; address/data hold when no request arrives.
  always_comb begin
    wb_valid_d = bus.w_enable;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (bus.w_enable) begin
      wb_addr_d = bus.w_addr;
      wb_data_d = wb_src_mux(bus.w_select, bus.w_alu, bus.w_id);
    end
  end

  // Next-state for the CPSR; independent of the register write path.
  always_comb begin
    cpsr_d = cpsr_q;
    if (bus.flags_we) begin
      cpsr_d = cpsr_from_vec(bus.flags_in);
    end
  end

  // Stage register and CPSR; reset drops any staged write so it never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      cpsr_q     <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      cpsr_q     <= cpsr_d;
    end
  end

  // Register array: commit the staged entry on the same edge a new one is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid_q) begin
      regs_q[wb_addr_q] <= wb_data_q;
    end
  end

  // Raw array lookups feeding the bypass ports.
  always_comb begin
    arr_val_0 = regs_q[bus.r_addr_0];
    arr_val_1 = regs_q[bus.r_addr_1];
  end

  reg_read_port u_read_port_0 (
    .r_addr_i   (bus.r_addr_0),
    .arr_val_i  (arr_val_0),
    .wb_valid_i (wb_valid_q),
    .wb_addr_i  (wb_addr_q),
    .wb_data_i  (wb_data_q),
    .r_val_o    (bus.r_val_0)
  );

  reg_read_port u_read_port_1 (
    .r_addr_i   (bus.r_addr_1),
    .arr_val_i  (arr_val_1),
    .wb_valid_i (wb_valid_q),
    .wb_addr_i  (wb_addr_q),
    .wb_data_i  (wb_data_q),
    .r_val_o    (bus.r_val_1)
  );

  // Status outputs straight from registered state.
  always_comb begin
    bus.flags      = cpsr_to_vec(cpsr_q);
    bus.wb_pending = wb_valid_q;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants.
module tb_reg_file_wb;
  import scc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  reg_file_wb_if bus ();

  reg_file_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req_write(input logic [2:0] a, input logic sel, input logic [31:0] d);
    bus.w_enable = 1'b1;
    bus.w_select = sel;
    bus.w_addr   = a;
    bus.w_alu    = sel ? 32'h0 : d;
    bus.w_id     = sel ? d : 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n        = 1'b0;
    bus.w_enable = 1'b0;
    bus.w_select = 1'b0;
    bus.w_addr   = '0;
    bus.w_alu    = '0;
    bus.w_id     = '0;
    bus.flags_we = 1'b0;
    bus.flags_in = 4'b0000;
    bus.r_addr_0 = 3'd0;
    bus.r_addr_1 = 3'd7;
    #1;
    check("reset r_val_0", bus.r_val_0, 32'h0);
    check("reset r_val_1", bus.r_val_1, 32'h0);
    check("reset flags", {28'h0, bus.flags}, 32'h0);
    check("reset pending", {31'h0, bus.wb_pending}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Source select: ALU then ID
    req_write(3'd2, W_SEL_ALU, 32'h0000_1234);
    tick();
    req_write(3'd5, W_SEL_ID, 32'hFFFF_8000);
    tick();
    bus.w_enable = 1'b0;
    tick();
    bus.r_addr_0 = 3'd2;
    bus.r_addr_1 = 3'd5;
    #1;
    check("src alu r2", bus.r_val_0, 32'h0000_1234);
    check("src id r5", bus.r_val_1, 32'hFFFF_8000);

    // Bypass timing
    bus.r_addr_0 = 3'd4;
    req_write(3'd4, W_SEL_ALU, 32'hDEAD_BEEF);
    #1;
    check("byp same cycle", bus.r_val_0, 32'h0);
    check("byp pend N", {31'h0, bus.wb_pending}, 32'h0);
    tick();
    bus.w_enable = 1'b0;
    #1;
    check("byp N+1", bus.r_val_0, 32'hDEAD_BEEF);
    check("byp pend N+1", {31'h0, bus.wb_pending}, 32'h1);
    tick();
    #1;
    check("byp N+2", bus.r_val_0, 32'hDEAD_BEEF);
    check("byp pend N+2", {31'h0, bus.wb_pending}, 32'h0);

    // Same-address back-to-back
    bus.r_addr_0 = 3'd1;
    bus.r_addr_1 = 3'd1;
    req_write(3'd1, W_SEL_ALU, 32'd5);
    tick();
    req_write(3'd1, W_SEL_ID, 32'd9);
    #1;
    check("b2b first p0", bus.r_val_0, 32'd5);
    check("b2b first p1", bus.r_val_1, 32'd5);
    tick();
    bus.w_enable = 1'b0;
    #1;
    check("b2b second p0", bus.r_val_0, 32'd9);
    check("b2b second p1", bus.r_val_1, 32'd9);
    tick();
    #1;
    check("b2b array r1", bus.r_val_0, 32'd9);
    check("b2b pending", {31'h0, bus.wb_pending}, 32'h0);

    // Dual port, different addresses
    bus.r_addr_0 = 3'd6;
    bus.r_addr_1 = 3'd7;
    req_write(3'd6, W_SEL_ALU, 32'd7);
    tick();
    req_write(3'd7, W_SEL_ALU, 32'd8);
    tick();
    bus.w_enable = 1'b0;
    #1;
    check("dual r6 array", bus.r_val_0, 32'd7);
    check("dual r7 bypass", bus.r_val_1, 32'd8);
    tick();
    #1;
    check("dual r6", bus.r_val_0, 32'd7);
    check("dual r7", bus.r_val_1, 32'd8);

    // Flags with simultaneous write to r0
    bus.r_addr_0 = 3'd0;
    bus.flags_we = 1'b1;
    bus.flags_in = 4'b1010;
    req_write(3'd0, W_SEL_ALU, 32'h0000_0055);
    #1;
    check("flags no bypass", {28'h0, bus.flags}, 32'h0);
    tick();
    bus.flags_we = 1'b0;
    bus.flags_in = 4'b0101;
    bus.w_enable = 1'b0;
    #1;
    check("flags update", {28'h0, bus.flags}, 32'hA);
    check("flags r0 bypass", bus.r_val_0, 32'h55);
    tick();
    #1;
    check("flags hold", {28'h0, bus.flags}, 32'hA);
    check("r0 array", bus.r_val_0, 32'h55);

    // Mid-run reset with a write staged
    bus.r_addr_0 = 3'd3;
    bus.r_addr_1 = 3'd2;
    req_write(3'd3, W_SEL_ALU, 32'h0000_ABCD);
    tick();
    bus.w_enable = 1'b0;
    #1;
    check("pre-rst staged", bus.r_val_0, 32'h0000_ABCD);
    check("pre-rst pending", {31'h0, bus.wb_pending}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst r_val_0", bus.r_val_0, 32'h0);
    check("rst r_val_1", bus.r_val_1, 32'h0);
    check("rst flags", {28'h0, bus.flags}, 32'h0);
    check("rst pending", {31'h0, bus.wb_pending}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("post-rst r3", bus.r_val_0, 32'h0);
    check("post-rst r2", bus.r_val_1, 32'h0);
    bus.r_addr_0 = 3'd4;
    bus.r_addr_1 = 3'd0;
    #1;
    check("post-rst r4", bus.r_val_0, 32'h0);
    check("post-rst r0", bus.r_val_1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Write-back and operand-read end of the execute-stage register interface. Accepts the EX stage's write request (`w_enable`, `w_select`, `w_alu`/`w_id`, destination register), stages it for one cycle, then commits it to an 8 x 32 general register file. Serves the two operand read ports (`r_val_0`, `r_val_1`) with bypass from the staged write, and holds the CPSR flag register (N, C, Z, V) that EX updates and branch logic reads.

## Interface
- `NUM_REGS`, 8: number of general registers.
- `DATA_W`, 32: register width.
- `ADDR_W`, 3: register address width; must equal clog2(`NUM_REGS`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `w_enable` in 1: write request from EX, active high.
- `w_select` in 1: write-data source; 0 = `w_alu`, 1 = `w_id`.
- `w_addr` in `ADDR_W`: destination register (EX `dest_reg`).
- `w_alu` in `DATA_W`: ALU result.
- `w_id` in `DATA_W`: immediate/move result.
- `flags_we` in 1: CPSR update strobe.
- `flags_in` in 4: new flags, bit order {N, C, Z, V} = [3:0].
- `r_addr_0`, `r_addr_1` in `ADDR_W`: operand register addresses.
- `r_val_0`, `r_val_1` out `DATA_W`: operand values, combinational.
- `flags` out 4: current CPSR, registered.
- `wb_pending` out 1: staged write not yet committed.

## Operation
- Stage register holds `wb_valid`, `wb_addr`, `wb_data`.
- Edge with `w_enable`=1: `wb_valid`<=1, `wb_addr`<=`w_addr`, `wb_data`<=(`w_select` ? `w_id` : `w_alu`).
- Edge with `w_enable`=0: `wb_valid`<=0.
- Edge with `wb_valid`=1: `regs[wb_addr]`<=`wb_data`. This commit occurs on the same edge that loads a new stage entry.
- Read port k: if `wb_valid` and `wb_addr`==`r_addr_k`, then `r_val_k`=`wb_data`; otherwise `r_val_k`=`regs[r_addr_k]`.
- No register is hardwired to zero.
- Both ports may read the same address, and each applies the bypass independently.
- CPSR: on an edge with `flags_we`=1, `flags`<=`flags_in`. `flags_we` and `w_enable` are independent and may both be high.
- `wb_pending` = `wb_valid`.

## Timing
- Reset (asynchronous assert, any cycle, including while a write is staged): all regs = 0, `wb_valid`=0, `wb_addr`=0, `wb_data`=0, `flags`=4'b0000. Hence `r_val_0`=`r_val_1`=0 and `wb_pending`=0.
- A staged write is dropped on reset and is never committed.
- Reset deassertion is synchronized externally. The first edge after release behaves normally.
- Write latency:
  - Request at edge N is visible on the read ports in cycle N+1, through the bypass.
  - It is in the array from edge N+1 onward.
  - It is never visible in the same cycle it is requested.
- Back-to-back writes to the same address (A then B): cycle after A reads A, next cycle reads B, array ends holding B. No lost or reordered writes.
- Back-to-back writes to different addresses: both commit, each one edge after staging.
- Flags: update visible the cycle after `flags_we`. There is no bypass from `flags_in`.
- `r_val_k` is purely combinational from `r_addr_k` and state; there is no read latency.

## Structure
- Shared package `scc_pkg`:
  - `NUM_REGS`, `DATA_W`, `ADDR_W`.
  - Flag bit indices `FLAG_N`=3, `FLAG_C`=2, `FLAG_Z`=1, `FLAG_V`=0.
  - `W_SEL_ALU`=0, `W_SEL_ID`=1.
  - Typedef `cpsr_t` (4-bit packed N, C, Z, V).
- One sub-module, `reg_read_port`: address compare plus bypass mux, instantiated twice.
- Array, stage register and CPSR live in the top.

## Test plan
- Reset: assert `rst_n`=0 mid-run with a write staged -> all `r_val`=0, `flags`=0000, `wb_pending`=0. After release, read r3 -> 0; the dropped write does not appear.
- Source select: write r2 with `w_select`=0, `w_alu`=32'h0000_1234; then write r5 with `w_select`=1, `w_id`=32'hFFFF_8000 -> r2=32'h0000_1234, r5=32'hFFFF_8000.
- Bypass: write r4=32'hDEAD_BEEF at edge N, `r_addr_0`=4 -> cycle N shows old 0, cycle N+1 shows DEAD_BEEF with `wb_pending`=1, cycle N+2 shows DEAD_BEEF with `wb_pending`=0.
- Same-address back-to-back: r1<=5 at edge N, r1<=9 at edge N+1, both ports on r1 -> reads 5 then 9 and holds 9; array r1=9.
- Dual port, different addresses: r6=7 and r7=8 committed; `r_addr_0`=6, `r_addr_1`=7 -> 7 and 8 in the same cycle.
- Flags: `flags_we`=1 with `flags_in`=4'b1010 together with a write to r0 -> `flags`=1010 the next cycle and r0 updated. `flags_we`=0 the following cycle -> `flags` holds 1010.
